// File: rtl/alu_issue_encoder_pkg.sv
// Shared definitions for the issue-side ALU command encoder: ALU opcodes, MIPS opcode/funct
// constants and the command record carried from decode through the output/skid registers.
package alu_issue_encoder_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 6;
    localparam int REG_W  = 5;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // ALU operation codes; the EX-stage ALU decodes exactly these values.
    localparam logic [CTRL_W-1:0] ALUOP_NOP  = 6'd0;
    localparam logic [CTRL_W-1:0] ALUOP_ADD  = 6'd1;
    localparam logic [CTRL_W-1:0] ALUOP_ADDU = 6'd2;
    localparam logic [CTRL_W-1:0] ALUOP_SUB  = 6'd3;
    localparam logic [CTRL_W-1:0] ALUOP_SUBU = 6'd4;
    localparam logic [CTRL_W-1:0] ALUOP_AND  = 6'd5;
    localparam logic [CTRL_W-1:0] ALUOP_OR   = 6'd6;
    localparam logic [CTRL_W-1:0] ALUOP_XOR  = 6'd7;
    localparam logic [CTRL_W-1:0] ALUOP_NOR  = 6'd8;
    localparam logic [CTRL_W-1:0] ALUOP_SLT  = 6'd9;
    localparam logic [CTRL_W-1:0] ALUOP_SLTU = 6'd10;
    localparam logic [CTRL_W-1:0] ALUOP_SLL  = 6'd11;
    localparam logic [CTRL_W-1:0] ALUOP_SRL  = 6'd12;
    localparam logic [CTRL_W-1:0] ALUOP_SRA  = 6'd13;
    localparam logic [CTRL_W-1:0] ALUOP_LUI  = 6'd14;
    localparam logic [CTRL_W-1:0] ALUOP_JUMP = 6'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] src0;
        logic [DATA_W-1:0] src1;
        logic              ov_check;
        logic [REG_W-1:0]  dst;
        logic              illegal;
    } alu_cmd_t;

    localparam alu_cmd_t CMD_IDLE = '{ctrl: ALUOP_NOP, default: '0};

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_encoder_if.sv
// ID-side and EX-side handshake bundle of the issue encoder; slave is the encoder's view.
interface alu_issue_encoder_if;
    import alu_issue_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] pc_plus4;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] alu_src0;
    logic [DATA_W-1:0] alu_src1;
    logic              ov_check;
    logic [REG_W-1:0]  dst_reg;
    logic              illegal;

    modport master (
        output in_valid, instr, rs_data, rt_data, pc_plus4, flush, out_ready,
        input  in_ready, out_valid, alu_control, alu_src0, alu_src1, ov_check, dst_reg, illegal
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data, pc_plus4, flush, out_ready,
        output in_ready, out_valid, alu_control, alu_src0, alu_src1, ov_check, dst_reg, illegal
    );

endinterface

// File: rtl/alu_issue_encoder_cmd_decode.sv
// Combinational MIPS instruction -> ALU command translation. Unknown encodings yield an
// all-zero command with illegal set so they still occupy a pipeline slot.
module alu_cmd_decode
    import alu_issue_encoder_pkg::*;
(
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_pc_plus4,
    output alu_cmd_t          o_cmd
);

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_src0;
    logic [DATA_W-1:0] w_src1;
    logic [REG_W-1:0]  w_dst;
    logic              w_legal;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];

    always_comb begin
        w_ctrl  = ALUOP_NOP;
        w_src0  = i_rs_data;
        w_src1  = i_rt_data;
        w_dst   = i_instr[15:11];
        w_legal = ENABLE;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD:  w_ctrl = ALUOP_ADD;
                    FN_ADDU: w_ctrl = ALUOP_ADDU;
                    FN_SUB:  w_ctrl = ALUOP_SUB;
                    FN_SUBU: w_ctrl = ALUOP_SUBU;
                    FN_AND:  w_ctrl = ALUOP_AND;
                    FN_OR:   w_ctrl = ALUOP_OR;
                    FN_XOR:  w_ctrl = ALUOP_XOR;
                    FN_NOR:  w_ctrl = ALUOP_NOR;
                    FN_SLT:  w_ctrl = ALUOP_SLT;
                    FN_SLTU: w_ctrl = ALUOP_SLTU;
                    FN_SLLV: w_ctrl = ALUOP_SLL;
                    FN_SRLV: w_ctrl = ALUOP_SRL;
                    FN_SRAV: w_ctrl = ALUOP_SRA;
                    // Immediate shifts carry the shift amount in src0, like the variable forms.
                    FN_SLL: begin w_ctrl = ALUOP_SLL; w_src0 = {27'b0, i_instr[10:6]}; end
                    FN_SRL: begin w_ctrl = ALUOP_SRL; w_src0 = {27'b0, i_instr[10:6]}; end
                    FN_SRA: begin w_ctrl = ALUOP_SRA; w_src0 = {27'b0, i_instr[10:6]}; end
                    default: w_legal = DISABLE;
                endcase
            end
            OP_J, OP_JAL: begin
                w_ctrl = ALUOP_JUMP;
                w_src0 = i_pc_plus4;
                w_src1 = {4'b0, i_instr[25:0], 2'b00};
                w_dst  = (w_op == OP_JAL) ? 5'd31 : 5'd0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_dst  = i_instr[20:16];
                w_src1 = sext16(i_instr[15:0]);
                case (w_op)
                    OP_ADDI:  w_ctrl = ALUOP_ADD;
                    OP_ADDIU: w_ctrl = ALUOP_ADDU;
                    OP_SLTI:  w_ctrl = ALUOP_SLT;
                    OP_SLTIU: w_ctrl = ALUOP_SLTU;
                    OP_ANDI: begin w_ctrl = ALUOP_AND; w_src1 = {16'b0, i_instr[15:0]}; end
                    OP_ORI:  begin w_ctrl = ALUOP_OR;  w_src1 = {16'b0, i_instr[15:0]}; end
                    OP_XORI: begin w_ctrl = ALUOP_XOR; w_src1 = {16'b0, i_instr[15:0]}; end
                    default: begin w_ctrl = ALUOP_LUI; w_src1 = {16'b0, i_instr[15:0]}; end
                endcase
            end
            default: w_legal = DISABLE;
        endcase
    end

    always_comb begin
        o_cmd = CMD_IDLE;
        if (w_legal) begin
            o_cmd.ctrl     = w_ctrl;
            o_cmd.src0     = w_src0;
            o_cmd.src1     = w_src1;
            o_cmd.ov_check = (w_ctrl == ALUOP_ADD) || (w_ctrl == ALUOP_SUB);
            o_cmd.dst      = w_dst;
        end else begin
            o_cmd.illegal  = ENABLE;
        end
    end

endmodule

// File: rtl/alu_issue_encoder.sv
// ID/EX issue stage: decodes the incoming instruction and holds the resulting ALU command in an
// output register backed by a one-entry skid buffer so EX back-pressure never loses an entry.
module alu_issue_encoder
    import alu_issue_encoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    alu_issue_encoder_if.slave  bus
);

    alu_cmd_t w_new_cmd;
    alu_cmd_t r_out_cmd;
    alu_cmd_t r_skid_cmd;
    logic     r_out_valid;
    logic     r_skid_valid;
    logic     w_accept;
    logic     w_out_free;

    alu_cmd_decode u_decode (
        .i_instr    (bus.instr),
        .i_rs_data  (bus.rs_data),
        .i_rt_data  (bus.rt_data),
        .i_pc_plus4 (bus.pc_plus4),
        .o_cmd      (w_new_cmd)
    );

    // A flush cycle swallows any instruction offered alongside it.
    assign w_accept   = bus.in_valid & ~r_skid_valid & ~bus.flush;
    assign w_out_free = ~r_out_valid | bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_cmd    <= CMD_IDLE;
            r_skid_cmd   <= CMD_IDLE;
        end else if (bus.flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // in_ready is low while the skid holds an entry, so no accept competes with it here.
            if (r_skid_valid) begin
                r_out_cmd    <= r_skid_cmd;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_cmd <= w_new_cmd;
                end
            end
        end else if (w_accept) begin
            r_skid_cmd   <= w_new_cmd;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready    = ~r_skid_valid;
    assign bus.out_valid   = r_out_valid;
    assign bus.alu_control = r_out_cmd.ctrl;
    assign bus.alu_src0    = r_out_cmd.src0;
    assign bus.alu_src1    = r_out_cmd.src1;
    assign bus.ov_check    = r_out_cmd.ov_check;
    assign bus.dst_reg     = r_out_cmd.dst;
    assign bus.illegal     = r_out_cmd.illegal;

endmodule

// File: tb/tb_alu_issue_encoder.sv
// Bench for alu_issue_encoder: directed cases plus random traffic checked by a queue scoreboard.
module tb_alu_issue_encoder;
    import alu_issue_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    alu_cmd_t exp_q[$];
    logic [5:0] rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    alu_issue_encoder_if bus ();

    alu_issue_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: instruction classes mapped straight from the MIPS ISA tables.
    function automatic alu_cmd_t model(input logic [31:0] w, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] pc);
        alu_cmd_t c;
        logic [5:0] op;
        logic [5:0] fn;
        logic ok;
        op = w[31:26];
        fn = w[5:0];
        c = '0;
        ok = 1'b1;
        if (op == 6'h00) begin
            case (fn)
                6'h20: c.ctrl = ALUOP_ADD;   6'h21: c.ctrl = ALUOP_ADDU;
                6'h22: c.ctrl = ALUOP_SUB;   6'h23: c.ctrl = ALUOP_SUBU;
                6'h24: c.ctrl = ALUOP_AND;   6'h25: c.ctrl = ALUOP_OR;
                6'h26: c.ctrl = ALUOP_XOR;   6'h27: c.ctrl = ALUOP_NOR;
                6'h2A: c.ctrl = ALUOP_SLT;   6'h2B: c.ctrl = ALUOP_SLTU;
                6'h00, 6'h04: c.ctrl = ALUOP_SLL;
                6'h02, 6'h06: c.ctrl = ALUOP_SRL;
                6'h03, 6'h07: c.ctrl = ALUOP_SRA;
                default: ok = 1'b0;
            endcase
            c.src0 = (fn < 6'h04) ? {27'b0, w[10:6]} : a;
            c.src1 = b;
            c.dst  = w[15:11];
        end else if (op == 6'h02 || op == 6'h03) begin
            c.ctrl = ALUOP_JUMP;
            c.src0 = pc;
            c.src1 = {4'b0, w[25:0], 2'b00};
            c.dst  = (op == 6'h03) ? 5'd31 : 5'd0;
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            case (op)
                6'h08: c.ctrl = ALUOP_ADD;  6'h09: c.ctrl = ALUOP_ADDU;
                6'h0A: c.ctrl = ALUOP_SLT;  6'h0B: c.ctrl = ALUOP_SLTU;
                6'h0C: c.ctrl = ALUOP_AND;  6'h0D: c.ctrl = ALUOP_OR;
                6'h0E: c.ctrl = ALUOP_XOR;  default: c.ctrl = ALUOP_LUI;
            endcase
            c.src0 = a;
            c.src1 = (op < 6'h0C) ? 32'(signed'(w[15:0])) : {16'h0, w[15:0]};
            c.dst  = w[20:16];
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            c = '0;
            c.illegal = 1'b1;
        end else begin
            c.ov_check = (c.ctrl == ALUOP_ADD) || (c.ctrl == ALUOP_SUB);
        end
        return c;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r < 4) begin
            w[31:26] = 6'h00;
            w[5:0] = rfn[$urandom_range(0, 15)];
        end else if (r < 8) begin
            w[31:26] = 6'($urandom_range(8, 15));
        end else if (r == 8) begin
            w[31:26] = 6'($urandom_range(2, 3));
        end
        if ($urandom_range(0, 7) == 0) w[20:11] = 10'd0;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        bus.rs_data  = a;
        bus.rt_data  = b;
        bus.pc_plus4 = 32'h0040_0104;
    endtask

    task automatic monitor();
        alu_cmd_t got;
        alu_cmd_t exp;
        forever begin
            @(negedge clk);
            if (!reset || bus.flush) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    got = '{ctrl: bus.alu_control, src0: bus.alu_src0, src1: bus.alu_src1,
                            ov_check: bus.ov_check, dst: bus.dst_reg, illegal: bus.illegal};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL scoreboard unexpected output got=%h", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            bad++;
                            $display("FAIL scoreboard got=%h want=%h", got, exp);
                        end else begin
                            $display("txn ok ctrl=%0d src0=%h src1=%h dst=%0d ov=%b ill=%b",
                                     got.ctrl, got.src0, got.src1, got.dst, got.ov_check, got.illegal);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model(bus.instr, bus.rs_data, bus.rt_data, bus.pc_plus4));
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_ctrl"}, 32'(bus.alu_control), 32'(ALUOP_NOP));
        chk({tag, "_src0"}, bus.alu_src0, 32'd0);
        chk({tag, "_src1"}, bus.alu_src1, 32'd0);
        chk({tag, "_dst"}, 32'(bus.dst_reg), 32'd0);
        chk({tag, "_ill"}, 32'(bus.illegal), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.instr = '0; bus.rs_data = '0; bus.rt_data = '0;
        bus.pc_plus4 = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        fork monitor(); join_none
        #1;
        chk_idle("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();

        // ADD $2,$4,$5
        drive(32'h0085_1020, 32'd5, 32'd7); step(); bus.in_valid = 1'b0;
        @(negedge clk);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_ctrl", 32'(bus.alu_control), 32'(ALUOP_ADD));
        chk("add_src0", bus.alu_src0, 32'd5);
        chk("add_src1", bus.alu_src1, 32'd7);
        chk("add_dst", 32'(bus.dst_reg), 32'd2);
        chk("add_ov", 32'(bus.ov_check), 32'd1);
        step();
        // SLL $3,$4,4
        drive(32'h0004_1900, 32'hDEAD_BEEF, 32'd1); step(); bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sll_ctrl", 32'(bus.alu_control), 32'(ALUOP_SLL));
        chk("sll_src0", bus.alu_src0, 32'd4);
        chk("sll_src1", bus.alu_src1, 32'd1);
        chk("sll_dst", 32'(bus.dst_reg), 32'd3);
        step();
        // ANDI $8,$9,0xFFFF
        drive(32'h3128_FFFF, 32'h1234, 32'h0); step(); bus.in_valid = 1'b0;
        @(negedge clk);
        chk("andi_src1", bus.alu_src1, 32'h0000_FFFF);
        chk("andi_dst", 32'(bus.dst_reg), 32'd8);
        chk("andi_ov", 32'(bus.ov_check), 32'd0);
        step();
        // ADDI $8,$9,-1
        drive(32'h2128_FFFF, 32'h1234, 32'h0); step(); bus.in_valid = 1'b0;
        @(negedge clk);
        chk("addi_src1", bus.alu_src1, 32'hFFFF_FFFF);
        chk("addi_ov", 32'(bus.ov_check), 32'd1);
        step();

        // Backpressure: three back-to-back, EX stalled
        bus.out_ready = 1'b0;
        drive(32'h0085_1020, 32'hA, 32'd1); step();
        drive(32'h0085_1020, 32'hB, 32'd1); step();
        drive(32'h0085_1020, 32'hC, 32'd1);
        @(negedge clk);
        chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head", bus.alu_src0, 32'hA);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", bus.alu_src0, 32'hA);
        step();
        @(negedge clk);
        chk("bp_second", bus.alu_src0, 32'hB);
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third", bus.alu_src0, 32'hC);
        chk("bp_third_valid", 32'(bus.out_valid), 32'd1);
        step();

        // Flush with full skid, then flush discarding an offered instruction
        bus.out_ready = 1'b0;
        drive(32'h0085_1020, 32'h1, 32'd1); step();
        drive(32'h0085_1020, 32'h2, 32'd1); step();
        bus.flush = 1'b1; step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.out_ready = 1'b1;
        drive(32'h0085_1020, 32'h3, 32'd1); bus.flush = 1'b1; step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_discard", 32'(bus.out_valid), 32'd0);
        step();

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        drive(32'h3128_FFFF, 32'h7, 32'd1); step();
        drive(32'h2128_FFFF, 32'h8, 32'd1); step();
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk_idle("midrst");
        step();
        #2 reset = 1'b1;
        bus.out_ready = 1'b1;
        step();
        drive(32'hFC00_0000, 32'h55, 32'h66); step(); bus.in_valid = 1'b0;
        @(negedge clk);
        chk("illegal_flag", 32'(bus.illegal), 32'd1);
        chk("illegal_ctrl", 32'(bus.alu_control), 32'(ALUOP_NOP));
        chk("illegal_src0", bus.alu_src0, 32'd0);
        chk("illegal_dst", 32'(bus.dst_reg), 32'd0);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            bus.instr     = rand_instr();
            bus.rs_data   = $urandom;
            bus.rt_data   = $urandom;
            bus.pc_plus4  = $urandom;
            step();
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && (exp_q.size() != 0 || bus.out_valid); i++) step();
        @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
